filter_capture_buffer: RTL and testbench

- Sits directly downstream of the IIR / moving-average filter stage and consumes its 64-bit output stream (`data`, `data_valid`).
- On a start command it discards a configurable number of leading samples, which lets the filter settle.
- It then decimates and stores a block of samples in an internal RAM, and raises `done`.
- The processor side drains the block through a simple request/valid read port.

---
 rtl/filter_capture_buffer.sv | 143 ++++++++++++++
 tb/tb_filter_capture_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_capture_buffer.sv
// Capture buffer behind the filter stage. After a start it skips settling samples,
// then decimates and stores a block in RAM that the host drains through a request/valid read port.
module filter_capture_buffer #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = 11
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              start,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data,
   input  logic [15:0]       skip,
   input  logic [15:0]       decim,
   input  logic [15:0]       n_samples,
   input  logic              rd_req,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   stored
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SKIP    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_FULL    = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t state, next_state;

   logic [15:0]       skip_q;
   logic [15:0]       decim_q;
   logic [ADDR_W:0]   n_q;
   logic [15:0]       skip_cnt;
   logic [15:0]       phase;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   stored_q;
   logic [ADDR_W:0]   rd_ptr;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              start_go;
   logic              sample;
   logic              skip_hit;
   logic              store;
   logic              last_write;
   logic              rd_go;
   logic [16:0]       n_wide;
   logic [ADDR_W:0]   n_clamped;

   // A sample arriving in the start cycle belongs to the old configuration and is dropped.
   assign start_go   = enable && start;
   assign sample     = enable && data_valid && !start;
   assign skip_hit   = (state == ST_SKIP) && sample && (({1'b0, skip_cnt} + 17'd1) == {1'b0, skip_q});
   assign store      = (state == ST_CAPTURE) && sample && (phase == 16'd0);
   assign last_write = store && ((stored_q + 1'b1) == n_q);

   assign n_wide    = {1'b0, n_samples};
   assign n_clamped = ((n_samples == 16'd0) || (n_wide > 17'(DEPTH))) ? DEPTH_C : n_samples[ADDR_W:0];

   // Read handshake: rd_req is sampled on a clock edge; if the block is FULL and unread
   // words remain, rd_data/rd_valid present that word for exactly one cycle after the edge.
   // Requests with nothing left, or outside FULL, are dropped and rd_data holds.
   assign rd_go = (state == ST_FULL) && rd_req && (rd_ptr < stored_q);

   always_comb begin
      next_state = state;
      if (start_go) begin
         next_state = (skip == 16'd0) ? ST_CAPTURE : ST_SKIP;
      end else begin
         case (state)
            ST_SKIP:    if (skip_hit)   next_state = ST_CAPTURE;
            ST_CAPTURE: if (last_write) next_state = ST_FULL;
            default:    next_state = state;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         skip_q     <= '0;
         decim_q    <= '0;
         n_q        <= '0;
         skip_cnt   <= '0;
         phase      <= '0;
         wr_ptr     <= '0;
         stored_q   <= '0;
         rd_ptr     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state      <= next_state;
         rd_valid_q <= rd_go;
         if (rd_go) begin
            rd_data_q <= mem[rd_ptr[ADDR_W-1:0]];
            rd_ptr    <= rd_ptr + 1'b1;
         end

         if (start_go) begin
            skip_q   <= skip;
            decim_q  <= (decim == 16'd0) ? 16'd1 : decim;
            n_q      <= n_clamped;
            skip_cnt <= '0;
            phase    <= '0;
            wr_ptr   <= '0;
            stored_q <= '0;
            rd_ptr   <= '0;
         end else if (sample) begin
            if (state == ST_SKIP) begin
               skip_cnt <= skip_cnt + 16'd1;
            end else if (state == ST_CAPTURE) begin
               phase <= (phase == 16'd0) ? (decim_q - 16'd1) : (phase - 16'd1);
               if (store) begin
                  wr_ptr   <= wr_ptr + 1'b1;
                  stored_q <= stored_q + 1'b1;
               end
            end
         end
      end
   end

   // RAM is not reset; its contents are only ever read below stored.
   always_ff @(posedge clock) begin
      if (store) begin
         mem[wr_ptr] <= data;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = (state == ST_SKIP) || (state == ST_CAPTURE);
   assign done     = (state == ST_FULL);
   assign stored   = stored_q;

endmodule

// File: tb/tb_filter_capture_buffer.sv
// Directed bench for filter_capture_buffer: hand-computed expected words are queued
// per block and drained back through the read port.
module tb_filter_capture_buffer;

   localparam int DATA_W = 64;
   localparam int DEPTH  = 2048;
   localparam int ADDR_W = 11;

   logic              clock;
   logic              reset_n;
   logic              enable;
   logic              start;
   logic              data_valid;
   logic [DATA_W-1:0] data;
   logic [15:0]       skip;
   logic [15:0]       decim;
   logic [15:0]       n_samples;
   logic              rd_req;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   stored;

   logic [DATA_W-1:0] exp_q[$];
   int n_checks;
   int n_errors;

   filter_capture_buffer #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .enable    (enable),
      .start     (start),
      .data_valid(data_valid),
      .data      (data),
      .skip      (skip),
      .decim     (decim),
      .n_samples (n_samples),
      .rd_req    (rd_req),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .done      (done),
      .stored    (stored)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},     64'(busy),     64'd0);
      check({tag, "_done"},     64'(done),     64'd0);
      check({tag, "_stored"},   64'(stored),   64'd0);
      check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
      check({tag, "_rd_data"},  rd_data,       64'd0);
   endtask

   // driver tasks
   task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
      skip      = s;
      decim     = d;
      n_samples = n;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic feed(input logic [DATA_W-1:0] v);
      data       = v;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
   endtask

   task automatic read_one(input string tag, input logic [DATA_W-1:0] exp);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check({tag, "_rd_valid"}, 64'(rd_valid), 64'd1);
      check({tag, "_rd_data"},  rd_data,       exp);
   endtask

   // Back-to-back drain of the scoreboard, then one extra request that must be ignored.
   task automatic drain(input string tag);
      logic [DATA_W-1:0] last;
      last   = '0;
      rd_req = 1'b1;
      while (exp_q.size() > 0) begin
         last = exp_q.pop_front();
         tick();
         check({tag, "_rd_valid"}, 64'(rd_valid), 64'd1);
         check({tag, "_rd_data"},  rd_data,       last);
      end
      tick();
      rd_req = 1'b0;
      check({tag, "_extra_valid"}, 64'(rd_valid), 64'd0);
      check({tag, "_extra_hold"},  rd_data,       last);
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      reset_n    = 1'b0;
      enable     = 1'b1;
      start      = 1'b0;
      data_valid = 1'b0;
      data       = '0;
      skip       = '0;
      decim      = '0;
      n_samples  = '0;
      rd_req     = 1'b0;
      tick();
      tick();
      check_idle_outputs("reset");
      reset_n = 1'b1;
      tick();

      // read in IDLE is ignored
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check("idle_rd_valid", 64'(rd_valid), 64'd0);

      // basic block: skip 0, decim 1, n 4
      do_start(16'd0, 16'd1, 16'd4);
      check("t1_busy", 64'(busy), 64'd1);
      feed(64'd10); feed(64'd20); feed(64'd30);
      check("t1_done_early", 64'(done), 64'd0);
      feed(64'd40);
      check("t1_done",   64'(done),   64'd1);
      check("t1_busy_lo", 64'(busy),  64'd0);
      check("t1_stored", 64'(stored), 64'd4);
      feed(64'd50);
      check("t1_stored_after", 64'(stored), 64'd4);
      exp_q.push_back(64'd10); exp_q.push_back(64'd20);
      exp_q.push_back(64'd30); exp_q.push_back(64'd40);
      drain("t1");

      // skip 3, decim 2, n 3: inputs 1..12 keep 4,6,8
      do_start(16'd3, 16'd2, 16'd3);
      for (int v = 1; v <= 12; v++) begin
         feed(64'(v));
         if (v == 7 || v == 8) begin
            check("t2_done", 64'(done), (v >= 8) ? 64'd1 : 64'd0);
            check("t2_busy", 64'(busy), (v >= 8) ? 64'd0 : 64'd1);
         end
      end
      check("t2_stored", 64'(stored), 64'd3);
      exp_q.push_back(64'd4); exp_q.push_back(64'd6); exp_q.push_back(64'd8);
      drain("t2");

      // decim 0 / n 0 clamp to 1 / DEPTH, gapped input
      do_start(16'd0, 16'd0, 16'd0);
      for (int i = 0; i < DEPTH; i++) begin
         feed(64'(i + 5));
         exp_q.push_back(64'(i + 5));
         if (i == DEPTH - 2) check("t3_done_early", 64'(done), 64'd0);
         tick();
         tick();
      end
      check("t3_done",   64'(done),   64'd1);
      check("t3_stored", 64'(stored), 64'(DEPTH));
      feed(64'hdead);
      check("t3_stored_after", 64'(stored), 64'(DEPTH));
      drain("t3");

      // negative values bit-exact
      do_start(16'd0, 16'd1, 16'd2);
      feed(64'hffff_ffff_ffff_ffff);
      feed(64'h8000_0000_0000_0000);
      check("t4_done", 64'(done), 64'd1);
      exp_q.push_back(64'hffff_ffff_ffff_ffff);
      exp_q.push_back(64'h8000_0000_0000_0000);
      drain("t4");

      // enable low mid-capture drops samples and freezes counters
      do_start(16'd0, 16'd1, 16'd4);
      feed(64'd1); feed(64'd2);
      enable = 1'b0;
      for (int k = 0; k < 5; k++) feed(64'(100 + k));
      check("t5_stored_frozen", 64'(stored), 64'd2);
      check("t5_busy_frozen",   64'(busy),   64'd1);
      enable = 1'b1;
      feed(64'd3); feed(64'd4);
      check("t5_done", 64'(done), 64'd1);
      // reads work with enable low
      enable = 1'b0;
      read_one("t5_rd_en_lo", 64'd1);
      enable = 1'b1;
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check("t5_rd2", rd_data, 64'd2);
      // async reset while rd_valid is high
      reset_n = 1'b0;
      #1;
      check_idle_outputs("t6_rst_read");
      tick();
      reset_n = 1'b1;
      tick();

      // reset mid-capture, then fresh block
      do_start(16'd0, 16'd1, 16'd4);
      feed(64'd7); feed(64'd8);
      check("t6_stored_pre", 64'(stored), 64'd2);
      #2;
      reset_n = 1'b0;
      #1;
      check_idle_outputs("t6_rst_cap");
      tick();
      reset_n = 1'b1;
      tick();
      do_start(16'd0, 16'd1, 16'd2);
      feed(64'd21); feed(64'd22);
      check("t6_stored", 64'(stored), 64'd2);
      read_one("t6_rd", 64'd21);

      // start in FULL with a read in the same cycle: the read still returns
      skip      = 16'd0;
      decim     = 16'd1;
      n_samples = 16'd2;
      start     = 1'b1;
      rd_req    = 1'b1;
      tick();
      start     = 1'b0;
      rd_req    = 1'b0;
      check("t7_pend_valid", 64'(rd_valid), 64'd1);
      check("t7_pend_data",  rd_data,       64'd22);
      check("t7_busy",       64'(busy),     64'd1);
      check("t7_stored",     64'(stored),   64'd0);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check("t7_cap_rd_ignored", 64'(rd_valid), 64'd0);
      feed(64'd31); feed(64'd32);
      exp_q.push_back(64'd31); exp_q.push_back(64'd32);
      drain("t7");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
